// File: rtl/fc_argmax_1.sv
// fc_argmax_1: scans the FC output-neuron RAM and reports the signed argmax (index, value).
// Defining FC_ARGMAX_TOP2_EN adds the runner-up outputs second_index/second_value.
module fc_argmax_1 #(
    parameter int DATA_WIDTH_FC                = 16,
    parameter int FC_OUTNEURON_ADDR_WIDTH      = 9,
    parameter int FC_COUNT_OUT_NEURON_BITWIDTH = 4,
    parameter int OUTNEURON                    = 10,
    parameter int RD_LAT                       = 1
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    start,
    output logic [FC_OUTNEURON_ADDR_WIDTH-1:0]      fc_outneuron_rdaddress,
    input  logic [DATA_WIDTH_FC-1:0]                fc_outneuron_q,
    output logic                                    busy,
    output logic                                    done,
    output logic [FC_COUNT_OUT_NEURON_BITWIDTH-1:0] class_index,
    output logic [DATA_WIDTH_FC-1:0]                class_value
`ifdef FC_ARGMAX_TOP2_EN
    ,
    output logic [FC_COUNT_OUT_NEURON_BITWIDTH-1:0] second_index,
    output logic [DATA_WIDTH_FC-1:0]                second_value
`endif
);
    localparam int AW = FC_OUTNEURON_ADDR_WIDTH;
    localparam int CW = FC_COUNT_OUT_NEURON_BITWIDTH;
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    state_t state, state_nxt;
    logic [RD_LAT-1:0] tag_v;
    logic [AW-1:0] tag_i [RD_LAT];
    logic last_issue, word_v, last_word;
    logic [AW-1:0] word_i;
    logic signed [DATA_WIDTH_FC-1:0] word;
    assign last_issue = fc_outneuron_rdaddress == AW'(OUTNEURON - 1);
    assign word_v     = tag_v[RD_LAT-1];
    assign word_i     = tag_i[RD_LAT-1];
    assign word       = $signed(fc_outneuron_q);
    assign last_word  = word_v && word_i == AW'(OUTNEURON - 1);
    assign busy       = state == READ || state == DRAIN;
    assign done       = state == DONE;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? READ : IDLE;
            READ:    state_nxt = last_issue ? DRAIN : READ;
            DRAIN:   state_nxt = last_word ? DONE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state                  <= IDLE;
            fc_outneuron_rdaddress <= '0;
            tag_v                  <= '0;
            for (int k = 0; k < RD_LAT; k++) tag_i[k] <= '0;
            class_index            <= '0;
            class_value            <= '0;
`ifdef FC_ARGMAX_TOP2_EN
            second_index           <= '0;
            second_value           <= '0;
`endif
        end else begin
            state                  <= state_nxt;
            fc_outneuron_rdaddress <= (state == READ && !last_issue) ? fc_outneuron_rdaddress + 1'b1 :
                                      (state_nxt == DONE) ? '0 : fc_outneuron_rdaddress;
            // Tag pipeline mirrors the RAM latency so each returned word carries its address.
            tag_v[0] <= state == READ;
            tag_i[0] <= fc_outneuron_rdaddress;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_v[k] <= tag_v[k-1];
                tag_i[k] <= tag_i[k-1];
            end
            if (word_v) begin
                if (word_i == '0 || word > $signed(class_value)) begin
                    class_index <= CW'(word_i);
                    class_value <= word;
`ifdef FC_ARGMAX_TOP2_EN
                    if (word_i != '0) begin
                        second_index <= class_index;
                        second_value <= class_value;
                    end
                end else if (word_i == AW'(1) || word > $signed(second_value)) begin
                    // Index 1 seeds the runner-up so stale values from a prior scan never survive.
                    second_index <= CW'(word_i);
                    second_value <= word;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_fc_argmax_1.sv
// tb_fc_argmax_1: random and directed scans against a RAM model and an argmax reference.
module tb_fc_argmax_1;
    localparam int DW = 16, AW = 9, CW = 4, N = 10, RD_LAT = 1;
    localparam int DONE_CYC = N + RD_LAT + 1;
    logic clock = 0, reset, start;
    logic [AW-1:0] rdaddress;
    logic [DW-1:0] q;
    logic busy, done;
    logic [CW-1:0] class_index;
    logic [DW-1:0] class_value;
`ifdef FC_ARGMAX_TOP2_EN
    logic [CW-1:0] second_index;
    logic [DW-1:0] second_value;
`endif
    logic signed [DW-1:0] mem [N];
    logic [DW-1:0] pipe [RD_LAT];
    int vectors = 0, miscompares = 0;
    int prev_i = 0;
    logic [DW-1:0] prev_v = '0;

    fc_argmax_1 #(.RD_LAT(RD_LAT)) dut (
        .clock(clock), .reset(reset), .start(start),
        .fc_outneuron_rdaddress(rdaddress), .fc_outneuron_q(q),
        .busy(busy), .done(done), .class_index(class_index), .class_value(class_value)
`ifdef FC_ARGMAX_TOP2_EN
        , .second_index(second_index), .second_value(second_value)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        pipe[0] <= (rdaddress < AW'(N)) ? mem[rdaddress] : '0;
        for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign q = pipe[RD_LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic ref_model(output int bi, output logic signed [DW-1:0] bv,
                             output int si, output logic signed [DW-1:0] sv);
        bv = mem[0];
        foreach (mem[i]) if (mem[i] > bv) bv = mem[i];
        bi = -1;
        foreach (mem[i]) if (bi < 0 && mem[i] == bv) bi = i;
        si = -1;
        sv = '0;
        foreach (mem[i]) if (i != bi && (si < 0 || mem[i] > sv)) begin si = i; sv = mem[i]; end
    endtask

    task automatic run_scan(input bit hold);
        int bi, si;
        logic signed [DW-1:0] bv, sv;
        ref_model(bi, bv, si, sv);
        @(negedge clock) start = 1;
        for (int c = 1; c <= DONE_CYC; c++) begin
            @(negedge clock);
            if (!hold) start = 0;
            check("busy", busy, c < DONE_CYC);
            check("done", done, c == DONE_CYC);
            if (c <= N) check("rdaddress", rdaddress, c - 1);
            if (c == 1) check("hold_index", class_index, prev_i);
            if (c == 1) check("hold_value", class_value, prev_v);
        end
        check("class_index", class_index, bi);
        check("class_value", class_value, $unsigned(bv));
`ifdef FC_ARGMAX_TOP2_EN
        check("second_index", second_index, si);
        check("second_value", second_value, $unsigned(sv));
`endif
        @(negedge clock) start = 0;
        check("idle_busy", busy, 0);
        check("idle_rdaddress", rdaddress, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check("no_extra_done", {busy, done}, 0);
        end
        check("result_held", class_index, bi);
        prev_i = bi;
        prev_v = $unsigned(bv);
    endtask

    initial begin
        reset = 1;
        start = 0;
        foreach (mem[i]) mem[i] = '0;
        repeat (3) @(negedge clock);
        check("rst_outputs", {busy, done, class_index, class_value, rdaddress}, 0);
        reset = 0;
        mem = '{16'sd5, -16'sd3, 16'sd100, 16'sd7, 16'sd0, 16'sd2, 16'sd99, -16'sd128, 16'sd1, 16'sd4};
        run_scan(0);
        foreach (mem[i]) mem[i] = -16'sd20;
        run_scan(0);
        foreach (mem[i]) mem[i] = '0;
        mem[N-1] = 16'sd32767;
        run_scan(0);
        foreach (mem[i]) mem[i] = DW'($urandom);
        run_scan(1);
        // Reset in cycle 5 of a scan aborts it without a done pulse.
        foreach (mem[i]) mem[i] = DW'($urandom);
        @(negedge clock) start = 1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            start = 0;
        end
        reset = 1;
        @(negedge clock);
        check("midrst_outputs", {busy, done, class_index, class_value, rdaddress}, 0);
        reset = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clock);
            check("midrst_no_done", {busy, done}, 0);
        end
        prev_i = 0;
        prev_v = '0;
        run_scan(0);
        for (int r = 0; r < 8; r++) begin
            foreach (mem[i]) mem[i] = r[0] ? DW'($urandom) : DW'($urandom_range(6) - 3);
            run_scan(r == 5);
        end
        mem = '{-16'sd32768, -16'sd32768, -16'sd32767, -16'sd32768, -16'sd32768,
                -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32767, -16'sd32768};
        run_scan(0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
